// File: rtl/fifo_push_arbiter_if.sv
// fifo_push_arbiter_if: requester-side and FIFO-write-side signals of the push arbiter
interface fifo_push_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4
);
  localparam int IW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fifo_full;
  logic                      fifo_push;
  logic [DATA_W-1:0]         fifo_data_in;
  logic                      grant_valid;
  logic [IW-1:0]             grant_id;
  logic                      burst_done;
  logic [15:0]               xfer_count;
  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_push, fifo_data_in, grant_valid, grant_id, burst_done, xfer_count
  );
  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_push, fifo_data_in, grant_valid, grant_id, burst_done, xfer_count
  );
endinterface

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin burst arbiter sharing one FIFO write port among requesters
module fifo_push_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 4,
  parameter int BURST_LEN = 2
) (
  input  logic clk,
  input  logic reset,
  fifo_push_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BURST_LEN) + 1;
  typedef enum logic {ARB, LOCK} state_t;
  state_t state, state_n;
  logic [IW-1:0] grant_id, gid_n, winner, idx;
  logic [CW-1:0] burst_cnt, cnt_n;
  logic [15:0] xfer_count;
  logic found, lock, sel_valid, xfer, release_g;
  // first valid requester after the last grant, wrapping
  always_comb begin
    found = 1'b0;
    winner = grant_id;
    idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(grant_id) + k) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        winner = idx;
      end
    end
  end
  assign lock      = state == LOCK;
  assign sel_valid = bus.req_valid[grant_id];
  assign xfer      = lock & sel_valid & ~bus.fifo_full & ~reset;
  assign release_g = lock & ~reset & (~sel_valid | (xfer & (burst_cnt == CW'(BURST_LEN - 1))));
  assign bus.fifo_push    = xfer;
  assign bus.req_ready    = xfer ? NUM_REQ'(1) << grant_id : '0;
  assign bus.fifo_data_in = lock ? bus.req_data[grant_id*DATA_W +: DATA_W] : '0;
  assign bus.grant_valid  = lock;
  assign bus.grant_id     = grant_id;
  assign bus.burst_done   = release_g;
  assign bus.xfer_count   = xfer_count;
  always_comb begin
    state_n = state;
    gid_n = grant_id;
    cnt_n = burst_cnt;
    if (!lock) begin
      state_n = found ? LOCK : ARB;
      gid_n = winner;
      cnt_n = found ? '0 : burst_cnt;
    end else begin
      cnt_n = xfer ? burst_cnt + CW'(1) : burst_cnt;
      state_n = release_g ? ARB : LOCK;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB;
      grant_id <= IW'(NUM_REQ - 1);
      burst_cnt <= '0;
      xfer_count <= '0;
    end else begin
      state <= state_n;
      grant_id <= gid_n;
      burst_cnt <= cnt_n;
      xfer_count <= xfer_count + 16'(xfer);
    end
  end
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: directed and random stimulus against a behavioural grant/burst model
module tb_fifo_push_arbiter;
  localparam int N = 4;
  localparam int W = 4;
  localparam int B = 2;
  logic clk = 1'b0;
  logic reset;
  fifo_push_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();
  fifo_push_arbiter #(.NUM_REQ(N), .DATA_W(W), .BURST_LEN(B)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int owner, last, beats, total;
  logic [W-1:0] dat [N];
  logic [N-1:0] acc;
  logic [N-1:0] cur_v;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    owner = -1;
    last = N - 1;
    beats = 0;
    total = 0;
  endtask
  // one clock: drive inputs, check outputs mid-cycle, then advance the model
  task automatic step(input logic [N-1:0] v, input logic full, input logic rst, output logic [N-1:0] accepted);
    logic [N*W-1:0] flat;
    bit vv, x, bd;
    for (int i = 0; i < N; i++) flat[i*W +: W] = dat[i];
    bus.req_valid = v;
    bus.req_data = flat;
    bus.fifo_full = full;
    reset = rst;
    @(negedge clk);
    vv = owner >= 0 && v[owner];
    x = vv && !full && !rst;
    bd = owner >= 0 && !rst && (!vv || (x && beats + 1 == B));
    accepted = x ? N'(1) << owner : '0;
    check("push", 32'(bus.fifo_push), 32'(x));
    check("ready", 32'(bus.req_ready), 32'(accepted));
    if (!rst) begin
      check("data", 32'(bus.fifo_data_in), owner >= 0 ? 32'(dat[owner]) : 0);
      check("gvalid", 32'(bus.grant_valid), 32'(owner >= 0));
      check("gid", 32'(bus.grant_id), owner >= 0 ? owner : last);
      check("bdone", 32'(bus.burst_done), 32'(bd));
      check("count", 32'(bus.xfer_count), total);
    end
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else if (owner < 0) begin
      for (int k = 1; k <= N; k++)
        if (owner < 0 && v[(last + k) % N]) begin
          owner = (last + k) % N;
          last = owner;
          beats = 0;
        end
    end else begin
      if (x) begin
        beats++;
        total = (total + 1) % 65536;
      end
      if (bd) owner = -1;
    end
  endtask
  initial begin
    model_reset();
    for (int i = 0; i < N; i++) dat[i] = W'(i + 1);
    step('1, 1'b0, 1'b1, acc);
    step('1, 1'b0, 1'b1, acc);
    for (int c = 0; c < 12; c++) step(4'b1111, 1'b0, 1'b0, acc);
    check("burst12_count", 32'(bus.xfer_count), 8);
    step('0, 1'b0, 1'b1, acc);
    dat[2] = 4'hA;
    for (int c = 0; c < 8; c++) step(4'b0100, 1'b0, 1'b0, acc);
    step('0, 1'b0, 1'b1, acc);
    step(4'b0010, 1'b0, 1'b0, acc);
    step(4'b0010, 1'b0, 1'b0, acc);
    for (int c = 0; c < 3; c++) step(4'b0010, 1'b1, 1'b0, acc);
    check("stall_gid", 32'(bus.grant_id), 1);
    step(4'b0010, 1'b0, 1'b0, acc);
    check("stall_beat2", 32'(acc), 32'(4'b0010));
    step('0, 1'b0, 1'b1, acc);
    step(4'b1000, 1'b0, 1'b0, acc);
    step(4'b1000, 1'b0, 1'b0, acc);
    step(4'b0000, 1'b0, 1'b0, acc);
    step(4'b1111, 1'b0, 1'b0, acc);
    check("after_drop_gid", 32'(bus.grant_id), 0);
    step(4'b1111, 1'b0, 1'b0, acc);
    step(4'b1111, 1'b0, 1'b0, acc);
    step(4'b1111, 1'b0, 1'b1, acc);
    check("rst_count", 32'(bus.xfer_count), 0);
    step(4'b1111, 1'b0, 1'b0, acc);
    check("rst_first_gid", 32'(bus.grant_id), 0);
    for (int c = 0; c < 10; c++) step(4'b0000, $urandom_range(0, 1) == 1, 1'b0, acc);
    cur_v = '0;
    for (int c = 0; c < 2000; c++) begin
      step(cur_v, $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0, acc);
      for (int i = 0; i < N; i++)
        if (acc[i] || !cur_v[i]) begin
          dat[i] = W'($urandom);
          cur_v[i] = $urandom_range(0, 3) != 0;
        end else cur_v[i] = $urandom_range(0, 7) != 0;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
Round-robin arbiter that lets NUM_REQ requesters share the write port of one circular FIFO. It grants a single requester at a time and holds the grant for a burst of up to BURST_LEN beats. While granted, it drives the FIFO's push, data_in and full handshake, then rotates priority to the next requester. It sits between the producer blocks and the FIFO write side; the FIFO's pop side is untouched.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 4, data width per requester; matches FIFO data_in width
BURST_LEN, 2, maximum beats per grant before forced rotation (1..15)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  bit i: requester i has a beat to write
req_data  input  NUM_REQ*DATA_W  requester i data in bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  bit i: beat from requester i accepted this cycle
fifo_full  input  1  full flag from FIFO
fifo_push  output  1  push strobe to FIFO
fifo_data_in  output  DATA_W  data to FIFO
grant_valid  output  1  a requester currently holds the grant (state LOCK)
grant_id  output  clog2(NUM_REQ)  index of current/last granted requester
burst_done  output  1  one-cycle pulse on the cycle a grant is released
xfer_count  output  16  total accepted beats since reset; wraps at 65535->0

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- State machine, 2 states: ARB, LOCK. Reset -> ARB.
- Reset values: state=ARB, grant_id=NUM_REQ-1 (req 0 wins first), burst_cnt=0, xfer_count=0, grant_valid=0, burst_done=0.
- fifo_push, req_ready and fifo_data_in are combinational from registered state. While reset=1, fifo_push=0 and req_ready=0.
- ARB:
  - Scan req_valid starting at grant_id+1 mod NUM_REQ, wrapping; the first set bit wins.
  - On a win: grant_id<=winner, burst_cnt<=0, state<=LOCK.
  - No valid bits: stay in ARB, grant_id unchanged.
  - No transfer ever happens in ARB. This gives one bubble cycle per grant.
- LOCK:
  - xfer = req_valid[grant_id] & ~fifo_full.
  - fifo_push=xfer. req_ready[grant_id]=xfer; all other req_ready bits 0.
  - fifo_data_in = slice grant_id of req_data, driven regardless of xfer. It is 0 in ARB.
  - On xfer: burst_cnt++ and xfer_count++.
  - Release, i.e. state<=ARB and burst_done=1 that cycle, when either:
    - xfer occurs and burst_cnt==BURST_LEN-1 (the final beat is accepted), or
    - req_valid[grant_id]==0 (no beat that cycle).
  - fifo_full=1 with valid=1: stall in LOCK, no push, burst_cnt held, no release. A requester cannot lose its grant to backpressure.
- grant_valid = (state==LOCK).
- burst_done is a registered-decision, combinational pulse, asserted only in the release cycle.
- burst_cnt width is clog2(BURST_LEN)+1.
- Requester protocol: a beat is consumed only when valid&ready. The requester holds data stable while valid=1 and ready=0.
- Reset mid-burst aborts the grant: no push in the reset cycle, and priority restarts at requester 0.
- The arbiter never asserts fifo_push while fifo_full=1, so the FIFO never sees a push-while-full.

Test Plan:
- All req_valid=4'b1111, fifo_full=0, BURST_LEN=2 -> grant_id sequence 0,0,1,1,2,2,3,3,0 on push cycles; pattern per grant is 1 ARB cycle + 2 push cycles; xfer_count=8 after 12 cycles; burst_done after each second beat.
- Only req 2 valid, data 4'hA -> ARB picks 2 one cycle after reset release; pushes 4'hA on the next two cycles, releases, re-arbitrates, picks 2 again.
- Req 1 granted, fifo_full=1 for 3 cycles mid-burst -> fifo_push=0 and req_ready=0 for those 3 cycles; grant_valid stays 1, grant_id=1; the second beat is pushed on the first cycle full=0.
- Req 3 granted, drops valid after 1 beat -> burst_done pulses that cycle with no push; next ARB scans from 0; xfer_count +1 only.
- Reset asserted during LOCK with push pending -> fifo_push=0 in the reset cycle; after release with 4'b1111 valid, the first grant is requester 0 and xfer_count=0.
- req_valid=0 for 10 cycles -> state stays ARB, fifo_push=0, grant_valid=0, xfer_count unchanged.
